miriscv_dmem_ctrl: RTL and testbench

Data-memory controller that sits directly downstream of the core's load/store unit, on its memory-protocol side. It accepts word-aligned requests with byte enables, performs byte-masked writes and full-word reads on an internal word-addressed synchronous RAM, and inserts a programmable number of wait states. While a request is in flight it holds the core with a stall signal, and it flags illegal accesses.

---
 rtl/miriscv_dmem_ctrl.sv | 160 ++++++++++++++++
 tb/tb_miriscv_dmem_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/miriscv_dmem_ctrl.sv
// Data-memory controller: word-addressed synchronous RAM behind the LSU
// memory port, byte-masked writes, programmable wait states, stall and
// illegal-access error reporting.
`timescale 1ns/1ps
module miriscv_dmem_ctrl #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_stall_o,
    output logic        data_err_o
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [31:0] SPAN     = 32'(DEPTH * 4);
    localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [3:0]      r_cnt;

    // Captured request, used while waiting so input changes are ignored
    logic            r_we;
    logic [3:0]      r_be;
    logic [AW-1:0]   r_idx;
    logic [31:0]     r_wdata;
    logic            r_err;

    logic [31:0]     r_rdata;
    logic            r_err_o;
    logic [31:0]     mem [DEPTH];

    logic [31:0]     w_off;
    logic [AW-1:0]   w_req_idx;
    logic            w_req_err;
    logic            w_stall;
    logic            w_accept;
    logic            w_exec;
    logic            w_from_idle;
    logic            w_ex_we;
    logic            w_ex_err;
    logic [3:0]      w_ex_be;
    logic [AW-1:0]   w_ex_idx;
    logic [31:0]     w_ex_wdata;

    // Offset from the window base; addresses below BASE_ADDR wrap to huge values
    assign w_off     = data_addr_i - BASE_ADDR;
    assign w_req_idx = w_off[AW+1:2];
    assign w_accept  = (r_state == S_IDLE) && data_req_i;

    // Classify the incoming request as legal or illegal
    always_comb begin
        w_req_err = (w_off >= SPAN);
        case (data_be_i)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: ;
            4'b0011, 4'b1100: if (data_addr_i[0])            w_req_err = 1'b1;
            4'b1111:          if (data_addr_i[1:0] != 2'b00) w_req_err = 1'b1;
            default:          w_req_err = 1'b1;
        endcase
    end

    // Next-state and stall decode
    always_comb begin
        w_next  = r_state;
        w_stall = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_stall = data_req_i;
                if (data_req_i) begin
                    if (WAIT_CYCLES > 0) w_next = S_WAIT;
                    else                 w_next = S_RESP;
                end
            end
            S_WAIT: begin
                w_stall = 1'b1;
                if (r_cnt == 4'd0) w_next = S_RESP;
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (rst_i) w_stall = 1'b0;
    end

    // With zero wait states the execute edge is the acceptance edge, so the
    // live inputs are used instead of the not-yet-loaded request registers.
    assign w_exec      = (w_next == S_RESP) && (r_state != S_RESP);
    assign w_from_idle = (r_state == S_IDLE);
    assign w_ex_we     = w_from_idle ? data_we_i    : r_we;
    assign w_ex_be     = w_from_idle ? data_be_i    : r_be;
    assign w_ex_idx    = w_from_idle ? w_req_idx    : r_idx;
    assign w_ex_wdata  = w_from_idle ? data_wdata_i : r_wdata;
    assign w_ex_err    = w_from_idle ? w_req_err    : r_err;

    // State register and wait-state counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept)
                r_cnt <= CNT_INIT;
            else if (r_state == S_WAIT && r_cnt != 4'd0)
                r_cnt <= r_cnt - 4'd1;
        end
    end

    // Request capture on acceptance
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_we    <= data_we_i;
            r_be    <= data_be_i;
            r_idx   <= w_req_idx;
            r_wdata <= data_wdata_i;
            r_err   <= w_req_err;
        end
    end

    // Byte-masked RAM write on the execute edge; reset aborts it
    always_ff @(posedge clk_i) begin
        if (!rst_i && w_exec && w_ex_we && !w_ex_err) begin
            for (int unsigned n = 0; n < 4; n++) begin
                if (w_ex_be[n]) mem[w_ex_idx][8*n +: 8] <= w_ex_wdata[8*n +: 8];
            end
        end
    end

    // Registered read data and one-cycle error flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rdata <= '0;
            r_err_o <= 1'b0;
        end else begin
            r_err_o <= w_exec && w_ex_err;
            if (w_exec) begin
                if (w_ex_err)      r_rdata <= '0;
                else if (!w_ex_we) r_rdata <= mem[w_ex_idx];
            end
        end
    end

    assign data_rdata_o = r_rdata;
    assign data_err_o   = r_err_o;
    assign data_stall_o = w_stall;

endmodule

// File: tb/tb_miriscv_dmem_ctrl.sv
// Self-checking bench for miriscv_dmem_ctrl: three instances with
// WAIT_CYCLES 1, 0 and 2, scoreboard of expected responses per access.
`timescale 1ns/1ps
module tb_miriscv_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req   [3];
    logic        we    [3];
    logic [3:0]  be    [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic        stall [3];
    logic        err   [3];

    always #5 clk = ~clk;

    miriscv_dmem_ctrl #(.DEPTH(1024), .WAIT_CYCLES(1), .BASE_ADDR(32'h0000_0000)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .data_req_i(req[0]), .data_we_i(we[0]), .data_be_i(be[0]),
        .data_addr_i(addr[0]), .data_wdata_i(wdata[0]), .data_rdata_o(rdata[0]),
        .data_stall_o(stall[0]), .data_err_o(err[0]));

    miriscv_dmem_ctrl #(.DEPTH(64), .WAIT_CYCLES(0), .BASE_ADDR(32'h8000_0000)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .data_req_i(req[1]), .data_we_i(we[1]), .data_be_i(be[1]),
        .data_addr_i(addr[1]), .data_wdata_i(wdata[1]), .data_rdata_o(rdata[1]),
        .data_stall_o(stall[1]), .data_err_o(err[1]));

    miriscv_dmem_ctrl #(.DEPTH(16), .WAIT_CYCLES(2), .BASE_ADDR(32'h0000_0100)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .data_req_i(req[2]), .data_we_i(we[2]), .data_be_i(be[2]),
        .data_addr_i(addr[2]), .data_wdata_i(wdata[2]), .data_rdata_o(rdata[2]),
        .data_stall_o(stall[2]), .data_err_o(err[2]));

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
        int          stalls;
    } exp_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        err_after;
        int          stalls;
        time         t;
    } obs_t;

    exp_t exp_q[$];
    obs_t obs_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void expect_resp(input string nm, input logic [31:0] rd,
                                        input logic er, input int st);
        exp_t e;
        e.name = nm; e.rdata = rd; e.err = er; e.stalls = st;
        exp_q.push_back(e);
    endfunction

    // Drive one request, hold it until the stall drops (bounded), record the
    // response cycle and the error flag one edge later. Leaves req high in IDLE.
    task automatic bus_access(input int d, input logic w, input logic [3:0] b,
                              input logic [31:0] a, input logic [31:0] wd);
        obs_t o;
        int   n;
        @(negedge clk);
        req[d] = 1'b1; we[d] = w; be[d] = b; addr[d] = a; wdata[d] = wd;
        #1;
        o.stalls = 0;
        n = 0;
        while (stall[d] === 1'b1 && n < 50) begin
            o.stalls++;
            n++;
            @(negedge clk);
            #1;
        end
        o.rdata = rdata[d];
        o.err   = err[d];
        o.t     = $time;
        @(posedge clk);
        #1;
        o.err_after = err[d];
        obs_q.push_back(o);
    endtask

    task automatic release_bus(input int d);
        @(negedge clk);
        req[d] = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            n_cmp++; if (stall[d] !== 1'b0) begin n_bad++; $display("FAIL reset_stall[%0d]: got %b expected 0", d, stall[d]); end
            n_cmp++; if (rdata[d] !== 32'h0) begin n_bad++; $display("FAIL reset_rdata[%0d]: got %h expected 00000000", d, rdata[d]); end
            n_cmp++; if (err[d] !== 1'b0) begin n_bad++; $display("FAIL reset_err[%0d]: got %b expected 0", d, err[d]); end
        end
        @(negedge clk);
        rst = 1'b0;

        expect_resp("rst_prewrite", 32'h0, 1'b0, 2);
        bus_access(0, 1'b1, 4'b1111, 32'h10, 32'h0BAD_F00D);
        release_bus(0);

        // Abort a write while it sits in the wait state
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; be[0] = 4'b1111; addr[0] = 32'h10; wdata[0] = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++; if (stall[0] !== 1'b0) begin n_bad++; $display("FAIL midreset_stall_comb: got %b expected 0", stall[0]); end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (stall[0] !== 1'b0) begin n_bad++; $display("FAIL midreset_stall: got %b expected 0", stall[0]); end
        n_cmp++; if (rdata[0] !== 32'h0) begin n_bad++; $display("FAIL midreset_rdata: got %h expected 00000000", rdata[0]); end
        n_cmp++; if (err[0] !== 1'b0) begin n_bad++; $display("FAIL midreset_err: got %b expected 0", err[0]); end
        @(negedge clk);
        rst = 1'b0;
        req[0] = 1'b0;

        expect_resp("rst_readback", 32'h0BAD_F00D, 1'b0, 2);
        bus_access(0, 1'b0, 4'b1111, 32'h10, 32'h0);
        release_bus(0);

        while (exp_q.size() > 0) begin
            exp_t e;
            obs_t o;
            e = exp_q.pop_front();
            if (obs_q.size() == 0) begin n_cmp++; n_bad++; $display("FAIL %s: no response recorded", e.name); continue; end
            o = obs_q.pop_front();
            n_cmp++; if (o.rdata !== e.rdata) begin n_bad++; $display("FAIL %s rdata: got %h expected %h", e.name, o.rdata, e.rdata); end
            n_cmp++; if (o.err !== e.err) begin n_bad++; $display("FAIL %s err: got %b expected %b", e.name, o.err, e.err); end
            n_cmp++; if (o.stalls != e.stalls) begin n_bad++; $display("FAIL %s stalls: got %0d expected %0d", e.name, o.stalls, e.stalls); end
        end
    endtask

    task automatic test_word_rw;
        expect_resp("word_write", 32'h0BAD_F00D, 1'b0, 2);
        bus_access(0, 1'b1, 4'b1111, 32'h40, 32'h1234_5678);
        expect_resp("word_read", 32'h1234_5678, 1'b0, 2);
        bus_access(0, 1'b0, 4'b1111, 32'h40, 32'h0);
        release_bus(0);

        while (exp_q.size() > 0) begin
            exp_t e;
            obs_t o;
            e = exp_q.pop_front();
            if (obs_q.size() == 0) begin n_cmp++; n_bad++; $display("FAIL %s: no response recorded", e.name); continue; end
            o = obs_q.pop_front();
            n_cmp++; if (o.rdata !== e.rdata) begin n_bad++; $display("FAIL %s rdata: got %h expected %h", e.name, o.rdata, e.rdata); end
            n_cmp++; if (o.err !== e.err) begin n_bad++; $display("FAIL %s err: got %b expected %b", e.name, o.err, e.err); end
            n_cmp++; if (o.stalls != e.stalls) begin n_bad++; $display("FAIL %s stalls: got %0d expected %0d", e.name, o.stalls, e.stalls); end
        end
    endtask

    task automatic test_byte_mask;
        expect_resp("bm_full", 32'h1234_5678, 1'b0, 2);
        bus_access(0, 1'b1, 4'b1111, 32'h8, 32'hAAAA_AAAA);
        expect_resp("bm_lane1", 32'h1234_5678, 1'b0, 2);
        bus_access(0, 1'b1, 4'b0010, 32'h8, 32'h5555_5555);
        expect_resp("bm_upper", 32'h1234_5678, 1'b0, 2);
        bus_access(0, 1'b1, 4'b1100, 32'h8, 32'h5555_5555);
        expect_resp("bm_read", 32'h5555_55AA, 1'b0, 2);
        bus_access(0, 1'b0, 4'b1111, 32'h8, 32'h0);
        release_bus(0);

        while (exp_q.size() > 0) begin
            exp_t e;
            obs_t o;
            e = exp_q.pop_front();
            if (obs_q.size() == 0) begin n_cmp++; n_bad++; $display("FAIL %s: no response recorded", e.name); continue; end
            o = obs_q.pop_front();
            n_cmp++; if (o.rdata !== e.rdata) begin n_bad++; $display("FAIL %s rdata: got %h expected %h", e.name, o.rdata, e.rdata); end
            n_cmp++; if (o.err !== e.err) begin n_bad++; $display("FAIL %s err: got %b expected %b", e.name, o.err, e.err); end
        end
    endtask

    task automatic test_errors;
        expect_resp("err_pre4", 32'h5555_55AA, 1'b0, 2);
        bus_access(0, 1'b1, 4'b1111, 32'h4, 32'h1111_2222);
        expect_resp("err_pre0", 32'h5555_55AA, 1'b0, 2);
        bus_access(0, 1'b1, 4'b1111, 32'h0, 32'h3333_4444);
        expect_resp("err_prelast", 32'h5555_55AA, 1'b0, 2);
        bus_access(0, 1'b1, 4'b1111, 32'hFFC, 32'h7777_8888);
        expect_resp("err_rd4", 32'h1111_2222, 1'b0, 2);
        bus_access(0, 1'b0, 4'b1111, 32'h4, 32'h0);
        expect_resp("err_misaligned_word", 32'h0, 1'b1, 2);
        bus_access(0, 1'b1, 4'b1111, 32'h6, 32'hFFFF_FFFF);
        expect_resp("err_out_of_range", 32'h0, 1'b1, 2);
        bus_access(0, 1'b1, 4'b1111, 32'h1000, 32'hFFFF_FFFF);
        expect_resp("err_be0101", 32'h0, 1'b1, 2);
        bus_access(0, 1'b1, 4'b0101, 32'h4, 32'hFFFF_FFFF);
        expect_resp("err_be0000", 32'h0, 1'b1, 2);
        bus_access(0, 1'b1, 4'b0000, 32'h0, 32'hFFFF_FFFF);
        expect_resp("err_misaligned_half", 32'h0, 1'b1, 2);
        bus_access(0, 1'b1, 4'b0011, 32'h1, 32'hFFFF_FFFF);
        expect_resp("err_rd4_keep", 32'h1111_2222, 1'b0, 2);
        bus_access(0, 1'b0, 4'b1111, 32'h4, 32'h0);
        expect_resp("err_oob_read", 32'h0, 1'b1, 2);
        bus_access(0, 1'b0, 4'b1111, 32'h1000, 32'h0);
        expect_resp("err_rd0_keep", 32'h3333_4444, 1'b0, 2);
        bus_access(0, 1'b0, 4'b1111, 32'h0, 32'h0);
        expect_resp("err_rdlast", 32'h7777_8888, 1'b0, 2);
        bus_access(0, 1'b0, 4'b1111, 32'hFFC, 32'h0);
        release_bus(0);

        while (exp_q.size() > 0) begin
            exp_t e;
            obs_t o;
            e = exp_q.pop_front();
            if (obs_q.size() == 0) begin n_cmp++; n_bad++; $display("FAIL %s: no response recorded", e.name); continue; end
            o = obs_q.pop_front();
            n_cmp++; if (o.rdata !== e.rdata) begin n_bad++; $display("FAIL %s rdata: got %h expected %h", e.name, o.rdata, e.rdata); end
            n_cmp++; if (o.err !== e.err) begin n_bad++; $display("FAIL %s err: got %b expected %b", e.name, o.err, e.err); end
            n_cmp++; if (o.err_after !== 1'b0) begin n_bad++; $display("FAIL %s err_after: got %b expected 0", e.name, o.err_after); end
            n_cmp++; if (o.stalls != e.stalls) begin n_bad++; $display("FAIL %s stalls: got %0d expected %0d", e.name, o.stalls, e.stalls); end
        end
    endtask

    task automatic test_zero_wait;
        time prev_t;
        bit  have_prev;
        expect_resp("zw_w0", 32'h0, 1'b0, 1);
        bus_access(1, 1'b1, 4'b1111, 32'h8000_0000, 32'h0102_0304);
        expect_resp("zw_w1", 32'h0, 1'b0, 1);
        bus_access(1, 1'b1, 4'b1111, 32'h8000_0004, 32'h1122_3344);
        expect_resp("zw_w2", 32'h0, 1'b0, 1);
        bus_access(1, 1'b1, 4'b1111, 32'h8000_0008, 32'h5566_7788);
        expect_resp("zw_wlast", 32'h0, 1'b0, 1);
        bus_access(1, 1'b1, 4'b1111, 32'h8000_00FC, 32'h99AA_BBCC);
        expect_resp("zw_r0", 32'h0102_0304, 1'b0, 1);
        bus_access(1, 1'b0, 4'b1111, 32'h8000_0000, 32'h0);
        expect_resp("zw_r1", 32'h1122_3344, 1'b0, 1);
        bus_access(1, 1'b0, 4'b1111, 32'h8000_0004, 32'h0);
        expect_resp("zw_r2", 32'h5566_7788, 1'b0, 1);
        bus_access(1, 1'b0, 4'b1111, 32'h8000_0008, 32'h0);
        expect_resp("zw_rlast", 32'h99AA_BBCC, 1'b0, 1);
        bus_access(1, 1'b0, 4'b1111, 32'h8000_00FC, 32'h0);
        expect_resp("zw_below_base", 32'h0, 1'b1, 1);
        bus_access(1, 1'b0, 4'b1111, 32'h7FFF_FFFC, 32'h0);
        expect_resp("zw_past_end", 32'h0, 1'b1, 1);
        bus_access(1, 1'b0, 4'b1111, 32'h8000_0100, 32'h0);
        release_bus(1);

        have_prev = 1'b0;
        prev_t    = 0;
        while (exp_q.size() > 0) begin
            exp_t e;
            obs_t o;
            e = exp_q.pop_front();
            if (obs_q.size() == 0) begin n_cmp++; n_bad++; $display("FAIL %s: no response recorded", e.name); continue; end
            o = obs_q.pop_front();
            n_cmp++; if (o.rdata !== e.rdata) begin n_bad++; $display("FAIL %s rdata: got %h expected %h", e.name, o.rdata, e.rdata); end
            n_cmp++; if (o.err !== e.err) begin n_bad++; $display("FAIL %s err: got %b expected %b", e.name, o.err, e.err); end
            n_cmp++; if (o.stalls != e.stalls) begin n_bad++; $display("FAIL %s stalls: got %0d expected %0d", e.name, o.stalls, e.stalls); end
            if (have_prev) begin
                n_cmp++; if (o.t - prev_t != 20) begin n_bad++; $display("FAIL %s spacing: got %0t expected 20", e.name, o.t - prev_t); end
            end
            prev_t    = o.t;
            have_prev = 1'b1;
        end
    endtask

    task automatic test_back_to_back;
        time prev_t;
        bit  have_prev;
        expect_resp("b2b_r40", 32'h1234_5678, 1'b0, 2);
        bus_access(0, 1'b0, 4'b1111, 32'h40, 32'h0);
        expect_resp("b2b_r8", 32'h5555_55AA, 1'b0, 2);
        bus_access(0, 1'b0, 4'b1111, 32'h8, 32'h0);
        expect_resp("b2b_r10", 32'h0BAD_F00D, 1'b0, 2);
        bus_access(0, 1'b0, 4'b1111, 32'h10, 32'h0);
        release_bus(0);

        have_prev = 1'b0;
        prev_t    = 0;
        while (exp_q.size() > 0) begin
            exp_t e;
            obs_t o;
            e = exp_q.pop_front();
            if (obs_q.size() == 0) begin n_cmp++; n_bad++; $display("FAIL %s: no response recorded", e.name); continue; end
            o = obs_q.pop_front();
            n_cmp++; if (o.rdata !== e.rdata) begin n_bad++; $display("FAIL %s rdata: got %h expected %h", e.name, o.rdata, e.rdata); end
            if (have_prev) begin
                n_cmp++; if (o.t - prev_t != 30) begin n_bad++; $display("FAIL %s spacing: got %0t expected 30", e.name, o.t - prev_t); end
            end
            prev_t    = o.t;
            have_prev = 1'b1;
        end
    endtask

    task automatic test_held_req;
        logic exp_stall;
        expect_resp("held_prewrite", 32'h0, 1'b0, 3);
        bus_access(2, 1'b1, 4'b1111, 32'h108, 32'hCAFE_0001);
        while (exp_q.size() > 0) begin
            exp_t e;
            obs_t o;
            e = exp_q.pop_front();
            if (obs_q.size() == 0) begin n_cmp++; n_bad++; $display("FAIL %s: no response recorded", e.name); continue; end
            o = obs_q.pop_front();
            n_cmp++; if (o.stalls != e.stalls) begin n_bad++; $display("FAIL %s stalls: got %0d expected %0d", e.name, o.stalls, e.stalls); end
            n_cmp++; if (o.rdata !== e.rdata) begin n_bad++; $display("FAIL %s rdata: got %h expected %h", e.name, o.rdata, e.rdata); end
        end

        // Read held high: accepted at T, T+4, T+8; responses at T+3, T+7, T+11
        @(negedge clk);
        we[2] = 1'b0; be[2] = 4'b1111; addr[2] = 32'h108; req[2] = 1'b1;
        #1;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            exp_stall = ((i % 4) != 3);
            n_cmp++; if (stall[2] !== exp_stall) begin n_bad++; $display("FAIL held_stall cycle %0d: got %b expected %b", i, stall[2], exp_stall); end
            if (!exp_stall) begin
                n_cmp++; if (rdata[2] !== 32'hCAFE_0001) begin n_bad++; $display("FAIL held_rdata cycle %0d: got %h expected cafe0001", i, rdata[2]); end
            end
        end
        release_bus(2);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            req[d] = 1'b0; we[d] = 1'b0; be[d] = 4'b0000; addr[d] = '0; wdata[d] = '0;
        end
        test_reset;
        test_word_rw;
        test_byte_mask;
        test_errors;
        test_zero_wait;
        test_back_to_back;
        test_held_req;
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
